// File: rtl/sprite_overlay_ctrl.sv
// 1-bpp bitmap overlay for the VGA path: offset placement, power-of-two scaling,
// frame-latched show/colour and optional frame-counted blink. 3-cycle pixel latency.
module sprite_overlay_ctrl #(
  parameter int unsigned IMG_W        = 256,
  parameter int unsigned IMG_H        = 256,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned X0           = 0,
  parameter int unsigned Y0           = 0,
  parameter int unsigned SCALE_LOG2   = 0,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Ready_Sig,
  input  logic [10:0]       Column_Addr_Sig,
  input  logic [10:0]       Row_Addr_Sig,
  input  logic              Show_Sig,
  input  logic [2:0]        Color_Sig,
  input  logic              Blink_En,
  input  logic [IMG_W-1:0]  Rom_Data,
  output logic [ADDR_W-1:0] Rom_Addr,
  output logic              Red_Sig,
  output logic              Green_Sig,
  output logic              Blue_Sig,
  output logic              Frame_Tick
);

  localparam int unsigned CMP_W = 16;
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CMP_W-1:0] X_LO   = CMP_W'(X0);
  localparam logic [CMP_W-1:0] Y_LO   = CMP_W'(Y0);
  localparam logic [CMP_W-1:0] X_SPAN = CMP_W'(IMG_W << SCALE_LOG2);
  localparam logic [CMP_W-1:0] Y_SPAN = CMP_W'(IMG_H << SCALE_LOG2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Pipeline registers
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [COL_W-1:0]  col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic              win_s1_q, win_s1_d, win_s2_q, win_s2_d;
  logic [2:0]        rgb_q, rgb_d;

  // Frame-level control registers
  logic [10:0]       prev_row_q, prev_row_d;
  logic              tick_q, tick_d;
  logic              show_q, show_d;
  logic [2:0]        color_q, color_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;

  // Stage-0 window test and image coordinates
  logic [CMP_W-1:0]  col_off_c, row_off_c;
  logic              in_win_c;
  logic [ADDR_W-1:0] img_row_c;
  logic [COL_W-1:0]  img_col_c;
  logic [COL_W-1:0]  sel_idx_c;
  logic              pix_c;

  // Offsets wrap to large values left of / above the image, so one unsigned compare suffices
  always_comb begin
    col_off_c = CMP_W'(Column_Addr_Sig) - X_LO;
    row_off_c = CMP_W'(Row_Addr_Sig) - Y_LO;
    in_win_c  = Ready_Sig && (col_off_c < X_SPAN) && (row_off_c < Y_SPAN);
    img_row_c = '0;
    img_col_c = '0;
    if (in_win_c) begin
      img_row_c = ADDR_W'(row_off_c >> SCALE_LOG2);
      img_col_c = COL_W'(col_off_c >> SCALE_LOG2);
    end
  end

  // Pixel pipeline next-state; MSB of the ROM word is the leftmost pixel
  always_comb begin
    rom_addr_d = img_row_c;
    col_s1_d   = img_col_c;
    win_s1_d   = in_win_c;
    col_s2_d   = col_s1_q;
    win_s2_d   = win_s1_q;
    sel_idx_c  = COL_W'(IMG_W - 1) - col_s2_q;
    pix_c      = Rom_Data[sel_idx_c] & win_s2_q & show_q & phase_q;
    rgb_d      = pix_c ? color_q : 3'b000;
  end

  // Frame detection, frame-latched show/colour and blink counter
  always_comb begin
    prev_row_d = Row_Addr_Sig;
    tick_d     = (Row_Addr_Sig < prev_row_q);
    show_d     = show_q;
    color_d    = color_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    if (tick_q) begin
      show_d  = Show_Sig;
      color_d = Color_Sig;
    end
    if (!Blink_En || !show_q || (tick_q && !Show_Sig)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (tick_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rom_addr_q <= '0;
      col_s1_q   <= '0;
      win_s1_q   <= 1'b0;
      col_s2_q   <= '0;
      win_s2_q   <= 1'b0;
      rgb_q      <= 3'b000;
      prev_row_q <= '0;
      tick_q     <= 1'b0;
      show_q     <= 1'b0;
      color_q    <= 3'b000;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
    end else begin
      rom_addr_q <= rom_addr_d;
      col_s1_q   <= col_s1_d;
      win_s1_q   <= win_s1_d;
      col_s2_q   <= col_s2_d;
      win_s2_q   <= win_s2_d;
      rgb_q      <= rgb_d;
      prev_row_q <= prev_row_d;
      tick_q     <= tick_d;
      show_q     <= show_d;
      color_q    <= color_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign Rom_Addr   = rom_addr_q;
  assign Red_Sig    = rgb_q[2];
  assign Green_Sig  = rgb_q[1];
  assign Blue_Sig   = rgb_q[0];
  assign Frame_Tick = tick_q;

endmodule
